// File: rtl/bbox_scanner.sv
// Raster-order walker over an inclusive screen-space bounding box.
// Emits one pixel coordinate per valid/ready handshake, flagging the first and last pixel.
module bbox_scanner #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             box_valid,
    output logic             box_ready,
    input  logic [WIDTH-1:0] min_x,
    input  logic [WIDTH-1:0] max_x,
    input  logic [WIDTH-1:0] min_y,
    input  logic [WIDTH-1:0] max_y,
    input  logic             abort,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [WIDTH-1:0] pix_x,
    output logic [WIDTH-1:0] pix_y,
    output logic             pix_first,
    output logic             pix_last,
    output logic             busy
);
    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    logic [WIDTH-1:0] lo_x, hi_x, hi_y;
    logic             accept, box_ok, pix_hs, row_end, col_end;
    logic [WIDTH-1:0] nx, ny;

    assign box_ready = (state == IDLE);
    assign busy      = pix_valid;
    assign accept    = box_valid && box_ready;
    assign box_ok    = (min_x <= max_x) && (min_y <= max_y);
    assign pix_hs    = pix_valid && pix_ready;

    // Equality tests happen before incrementing, so a box touching 2^WIDTH-1 never wraps.
    assign row_end   = (pix_x == hi_x);
    assign col_end   = (pix_y == hi_y);

    always_comb begin
        nx = pix_x + ONE;
        ny = pix_y;
        if (row_end) begin
            nx = lo_x;
            ny = pix_y + ONE;
        end
    end

    // Only the bounds needed after the first pixel are kept (min_y is consumed at accept).
    always_ff @(posedge clk) begin
        if (accept) begin
            lo_x <= min_x;
            hi_x <= max_x;
            hi_y <= max_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_first <= 1'b0;
            pix_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // An inverted box is dropped silently, leaving the scanner ready.
                    if (accept && box_ok) begin
                        state     <= SCAN;
                        pix_valid <= 1'b1;
                        pix_x     <= min_x;
                        pix_y     <= min_y;
                        pix_first <= 1'b1;
                        pix_last  <= (min_x == max_x) && (min_y == max_y);
                    end
                end
                SCAN: begin
                    if (abort || (pix_hs && row_end && col_end)) begin
                        state     <= IDLE;
                        pix_valid <= 1'b0;
                        pix_first <= 1'b0;
                        pix_last  <= 1'b0;
                    end else if (pix_hs) begin
                        pix_x     <= nx;
                        pix_y     <= ny;
                        pix_first <= 1'b0;
                        pix_last  <= (nx == hi_x) && (ny == hi_y);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
